// File: rtl/ftdi_uplink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ftdi_uplink                                                  |
// | Description : Serial (clk+data, MSB first) to byte assembler, byte FIFO    |
// |               and FTDI synchronous 245-style TX FIFO write engine.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ftdi_uplink #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          ser_clk,
    input  logic                          ser_data,
    input  logic                          ftdi_txe_n,
    output logic                          ftdi_wr_n,
    output logic [7:0]                    ftdi_data_out,
    output logic                          ftdi_data_oe,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TOUT_MAX   = c_TW'(TIMEOUT - 1);
    localparam logic [c_LW-1:0] c_LEVEL_FULL = c_LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Synchronizers and edge detector
    logic [SYNC_STAGES-1:0] r_sclk_q, w_sclk_d;
    logic [SYNC_STAGES-1:0] r_sdat_q, w_sdat_d;
    logic                   r_sclk_prev_q;
    logic                   w_rise;
    logic                   w_sbit;

    // Assembler; only 7 bits are kept because the 8th goes straight to the FIFO
    logic [6:0]      r_shreg_q, w_shreg_d;
    logic [2:0]      r_bit_cnt_q, w_bit_cnt_d;
    logic [c_TW-1:0] r_tcnt_q, w_tcnt_d;
    logic            w_push;
    logic [7:0]      w_byte;

    // FIFO
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_LW-1:0] r_level_q, w_level_d;
    logic            r_ovf_q, w_ovf_d;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_ok;
    logic [7:0]      w_head;
    logic [7:0]      w_next;

    // Write engine
    state_t          r_state_q, w_state_d;
    logic            r_wr_n_q, w_wr_n_d;
    logic            r_oe_q, w_oe_d;
    logic [7:0]      r_data_q, w_data_d;

    always_comb begin
        w_sclk_d = {r_sclk_q[SYNC_STAGES-2:0], ser_clk};
        w_sdat_d = {r_sdat_q[SYNC_STAGES-2:0], ser_data};
    end

    assign w_rise = en & r_sclk_q[SYNC_STAGES-1] & ~r_sclk_prev_q;
    assign w_sbit = r_sdat_q[SYNC_STAGES-1];
    assign w_byte = {r_shreg_q, w_sbit};

    always_comb begin
        w_shreg_d   = r_shreg_q;
        w_bit_cnt_d = r_bit_cnt_q;
        w_tcnt_d    = r_tcnt_q;
        w_push      = 1'b0;
        if (!en) begin
            w_shreg_d   = '0;
            w_bit_cnt_d = '0;
            w_tcnt_d    = '0;
        end else if (w_rise) begin
            w_shreg_d   = w_byte[6:0];
            w_bit_cnt_d = r_bit_cnt_q + 3'd1;
            w_tcnt_d    = '0;
            w_push      = (r_bit_cnt_q == 3'd7);
        end else if (r_bit_cnt_q != 3'd0) begin
            // A stalled partial byte is dropped without any indication
            if (r_tcnt_q == c_TOUT_MAX) begin
                w_shreg_d   = '0;
                w_bit_cnt_d = '0;
                w_tcnt_d    = '0;
            end else begin
                w_tcnt_d = r_tcnt_q + c_TW'(1);
            end
        end
    end

    assign w_full    = (r_level_q == c_LEVEL_FULL);
    assign w_empty   = (r_level_q == '0);
    assign w_pop     = en & (r_state_q == ST_WRITE) & ~r_wr_n_q & ~ftdi_txe_n;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_head    = r_mem[r_rd_ptr_q];
    assign w_next    = r_mem[r_rd_ptr_q + c_AW'(1)];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        w_ovf_d    = r_ovf_q;
        if (!en) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
            w_ovf_d    = 1'b0;
        end else begin
            if (w_push_ok) begin
                w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                w_level_d = r_level_q + c_LW'(1);
            end else if (!w_push_ok && w_pop) begin
                w_level_d = r_level_q - c_LW'(1);
            end
            if (w_push && !w_push_ok) begin
                w_ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_wr_n_d  = r_wr_n_q;
        w_oe_d    = r_oe_q;
        w_data_d  = r_data_q;
        if (!en) begin
            w_state_d = ST_IDLE;
            w_wr_n_d  = 1'b1;
            w_oe_d    = 1'b0;
            w_data_d  = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_wr_n_d = 1'b1;
                    w_oe_d   = 1'b0;
                    if (!w_empty && !ftdi_txe_n) begin
                        w_data_d  = w_head;
                        w_oe_d    = 1'b1;
                        w_state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    w_oe_d    = 1'b1;
                    w_wr_n_d  = 1'b0;
                    w_state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    // A byte that pushes in on the last pop is picked up via IDLE
                    if (!ftdi_txe_n && (r_level_q > c_LW'(1))) begin
                        w_data_d = w_next;
                    end else begin
                        w_wr_n_d  = 1'b1;
                        w_oe_d    = 1'b0;
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_wr_n_d  = 1'b1;
                    w_oe_d    = 1'b0;
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr_q] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_q      <= '0;
            r_sdat_q      <= '0;
            r_sclk_prev_q <= 1'b0;
            r_shreg_q     <= '0;
            r_bit_cnt_q   <= '0;
            r_tcnt_q      <= '0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
            r_ovf_q       <= 1'b0;
            r_state_q     <= ST_IDLE;
            r_wr_n_q      <= 1'b1;
            r_oe_q        <= 1'b0;
            r_data_q      <= '0;
        end else begin
            r_sclk_q      <= w_sclk_d;
            r_sdat_q      <= w_sdat_d;
            r_sclk_prev_q <= r_sclk_q[SYNC_STAGES-1];
            r_shreg_q     <= w_shreg_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_tcnt_q      <= w_tcnt_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_level_q     <= w_level_d;
            r_ovf_q       <= w_ovf_d;
            r_state_q     <= w_state_d;
            r_wr_n_q      <= w_wr_n_d;
            r_oe_q        <= w_oe_d;
            r_data_q      <= w_data_d;
        end
    end

    assign ftdi_wr_n     = r_wr_n_q;
    assign ftdi_data_out = r_data_q;
    assign ftdi_data_oe  = r_oe_q;
    assign overflow      = r_ovf_q;
    assign fifo_level    = r_level_q;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_uplink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ftdi_uplink                                               |
// | Description : Self-checking bench for ftdi_uplink with a byte-queue model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ftdi_uplink;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int TOUT  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ser_clk = 1'b0;
    logic       ser_data = 1'b0;
    logic       txe_n = 1'b1;
    logic       wr_n;
    logic [7:0] dout;
    logic       oe;
    logic       ovf;
    logic [4:0] level;

    ftdi_uplink #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ser_clk      (ser_clk),
        .ser_data     (ser_data),
        .ftdi_txe_n   (txe_n),
        .ftdi_wr_n    (wr_n),
        .ftdi_data_out(dout),
        .ftdi_data_oe (oe),
        .overflow     (ovf),
        .fifo_level   (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Serial bits in flight: edge at which each one reaches the assembler
    int         ev_due[$];
    bit         ev_bit[$];

    // Byte-level model
    logic [7:0] exp_q[$];
    logic [7:0] wlog[$];
    bit         m_ovf = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_sh = '0;
    int         m_last = 0;
    bit         pop_pend = 1'b0;
    bit         en_pend = 1'b0;
    int         run = 0;
    int         max_run = 0;
    int         max_level = 0;
    bit         rnd_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : p_model
        bit popped;
        int pre;
        bit b;
        if (rst) begin
            exp_q.delete();
            ev_due.delete();
            ev_bit.delete();
            m_ovf = 1'b0; m_cnt = 0; m_sh = '0;
            pop_pend = 1'b0; en_pend = 1'b0; run = 0;
            chk("rst_wr_n", wr_n, 1);
            chk("rst_oe", oe, 0);
            chk("rst_data", dout, 0);
            chk("rst_level", level, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            if (!en_pend) begin
                exp_q.delete();
                m_ovf = 1'b0; m_cnt = 0; m_sh = '0;
                while (ev_due.size() > 0 && ev_due[0] <= edge_cnt) begin
                    void'(ev_due.pop_front());
                    void'(ev_bit.pop_front());
                end
            end else begin
                popped = pop_pend;
                pre = exp_q.size();
                if (popped) void'(exp_q.pop_front());
                while (ev_due.size() > 0 && ev_due[0] <= edge_cnt) begin
                    void'(ev_due.pop_front());
                    b = ev_bit.pop_front();
                    if (m_cnt > 0 && (edge_cnt - m_last) > TOUT) m_cnt = 0;
                    m_sh = {m_sh[6:0], b};
                    m_cnt++;
                    m_last = edge_cnt;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        if (pre < DEPTH || popped) exp_q.push_back(m_sh);
                        else m_ovf = 1'b1;
                    end
                end
            end
            chk("level", level, exp_q.size());
            chk("overflow", ovf, m_ovf);
            if (!wr_n) begin
                chk("oe_during_write", oe, 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_low_empty: got wr_n=0 expected no write with empty FIFO (t=%0t)", $time);
                end else begin
                    chk("data", dout, exp_q[0]);
                end
                run++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (level > max_level) max_level = level;
            if (!wr_n && !txe_n && en) wlog.push_back(dout);
            pop_pend = !wr_n && !txe_n;
            en_pend = en;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit b);
        int h;
        h = $urandom_range(3, 4);
        ser_data = b;
        tick(h);
        ser_clk = 1'b1;
        ev_due.push_back(edge_cnt + SYNC + 1);
        ev_bit.push_back(b);
        tick(h);
        ser_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(ev_due.size() == 0 && level == 0 && wr_n) && n < 2000) begin
            tick(1);
            n++;
        end
        tick(3);
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got level=%0d expected drain within 2000 cycles", name, level);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset
        txe_n = 1'b0;
        tick(3);
        rst = 1'b0;
        en = 1'b1;
        tick(2);
        chk("after_reset_level", level, 0);
        chk("after_reset_wr_n", wr_n, 1);

        // Basic transfer
        wlog.delete();
        send_byte(8'hA5);
        send_byte(8'h3C);
        wait_idle("basic");
        chk("basic_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("basic_b0", wlog[0], 8'hA5);
            chk("basic_b1", wlog[1], 8'h3C);
        end
        chk("basic_ovf", ovf, 0);

        // Overflow
        txe_n = 1'b1;
        wlog.delete();
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        tick(8);
        chk("ovf_level", level, 16);
        chk("ovf_flag", ovf, 1);
        max_run = 0;
        txe_n = 1'b0;
        wait_idle("ovf");
        chk("ovf_count", wlog.size(), 16);
        for (int i = 0; i < wlog.size() && i < 16; i++) chk("ovf_order", wlog[i], i);
        chk("ovf_burst_len", max_run, 16);
        chk("ovf_sticky", ovf, 1);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        chk("ovf_cleared", ovf, 0);

        // Backpressure
        txe_n = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        tick(8);
        txe_n = 1'b0;
        n = 0;
        while (!(!wr_n && dout == 8'h12) && n < 100) begin
            tick(1);
            n++;
        end
        chk("bp_reach_12", (n < 100) ? 1 : 0, 1);
        tick(1);
        txe_n = 1'b1;
        tick(6);
        chk("bp_hold_level", level, 2);
        chk("bp_hold_wr_n", wr_n, 1);
        txe_n = 1'b0;
        wait_idle("bp");
        chk("bp_count", wlog.size(), 4);
        for (int i = 0; i < wlog.size() && i < 4; i++) chk("bp_order", wlog[i], 8'h11 + i);

        // Timeout of a partial byte
        wlog.delete();
        max_level = 0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(TOUT + 20);
        send_byte(8'h81);
        wait_idle("tout");
        chk("tout_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("tout_byte", wlog[0], 8'h81);
        chk("tout_max_level", max_level, 1);

        // Flush
        txe_n = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(8);
        chk("flush_pre_level", level, 5);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(2);
        chk("flush_level", level, 0);
        chk("flush_ovf", ovf, 0);
        wlog.delete();
        txe_n = 1'b0;
        tick(10);
        chk("flush_no_writes", wlog.size(), 0);
        send_byte(8'h5A);
        wait_idle("flush");
        chk("flush_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("flush_byte", wlog[0], 8'h5A);

        // Asynchronous reset mid-cycle
        txe_n = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        tick(8);
        chk("arst_pre_level", level, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_wr_n", wr_n, 1);
        chk("arst_oe", oe, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        txe_n = 1'b0;

        // Randomized traffic with random backpressure
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    tick(1);
                    txe_n = ($urandom_range(0, 3) == 0);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        n = $urandom_range(1, 7);
                        for (int j = 0; j < n; j++) send_bit(1'($urandom));
                        tick(TOUT + 20);
                    end
                    send_byte(8'($urandom));
                    tick($urandom_range(0, 6));
                end
                rnd_on = 1'b0;
            end
        join
        txe_n = 1'b0;
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
